serial_word_rx: RTL and testbench
=================================

// Module: serial_word_rx
// PURPOSE
//  Deserializer for the wr_en/data_out serial stream produced by the test-bench shifter.
//  Samples one bit per clk while ser_en=1, MSB first, and assembles NUM_BITS-bit words.
//  Computes a parity bit per word and presents word+parity on a valid/ready output port.
//  Used as the receive end of the parity_bit bench and as a reusable capture block.
// PARAMETERS
//  NUM_BITS    3  word width in bits; legal range 1..255
//  PARITY_ODD  0  0: out_parity = ^word (even parity); 1: out_parity = ~^word (odd parity)
//  CNT_W       8  width of word_cnt
// PORTS
//  clk         in   1         clock, rising edge
//  rst_n       in   1         reset, asynchronous, active-low
//  ser_en      in   1         serial bit valid; ser_data is sampled only when 1
//  ser_data    in   1         serial data bit, MSB of the word first
//  flush       in   1         synchronous discard of the partially received word
//  out_ready   in   1         downstream accepts out_word/out_parity
//  out_valid   out  1         out_word/out_parity hold a completed word
//  out_word    out  NUM_BITS  assembled word; first received bit is at [NUM_BITS-1]
//  out_parity  out  1         parity of out_word per PARITY_ODD
//  bit_cnt     out  8         bits collected toward the current word (0..NUM_BITS-1)
//  word_cnt    out  CNT_W     completed words, counted whether accepted or dropped; wraps
//  overflow    out  1         sticky flag: a completed word was dropped
// BEHAVIOUR
//  Reset (async): shift_word=0, bit_cnt=0, out_valid=0, out_word=0, out_parity=0,
//   word_cnt=0, overflow=0. Any partial word is discarded.
//  Sampling: on each posedge with ser_en=1,
//   shift_word <= {shift_word[NUM_BITS-2:0], ser_data}, then bit_cnt++.
//   ser_en=0 holds all state, so gaps between bits are legal.
//  Completion: the edge that samples bit NUM_BITS-1 (bit_cnt==NUM_BITS-1, ser_en=1)
//   - resets bit_cnt to 0 and increments word_cnt (modulo 2^CNT_W);
//   - loads the full word {shift_word[NUM_BITS-2:0], ser_data} into out_word;
//   - loads its parity into out_parity and sets out_valid=1.
//   out_valid is therefore high in the cycle right after the last bit. Latency is 0 extra clocks.
//  Output handshake: the word transfers on an edge where out_valid=1 and out_ready=1.
//   out_valid clears on that edge unless a new word completes on the same edge.
//   out_word/out_parity are stable while out_valid=1 and out_ready=0.
//  Completion while out_valid=1:
//   - if out_ready=1, the old word transfers and the new word loads on the same edge,
//     so out_valid stays 1 and nothing is lost;
//   - if out_ready=0, the new word is dropped, out_word is unchanged, and overflow <= 1.
//  overflow clears only on reset.
//  flush=1: bit_cnt<=0 and shift_word<=0. flush overrides a simultaneous ser_en, so that
//   bit is discarded and no word completes. flush does not affect out_valid, out_word,
//   word_cnt or overflow.
//  NUM_BITS=1: every ser_en=1 sample completes a word. bit_cnt stays 0.
//  States are implicit: COLLECT (bit_cnt counting), then OUT_FULL (out_valid=1) until the
//   handshake. The two states overlap so that receive and drain are fully pipelined.
// TESTING
//  1 NUM_BITS=3, even parity: ser_en=1 for 3 clks with bits 1,0,1 -> out_valid=1 next cycle,
//    out_word=3'b101, out_parity=0, word_cnt=1
//  2 PARITY_ODD=1: send 1,1,0 -> out_word=3'b110, out_parity=1; with out_ready=1 the
//    handshake clears out_valid on the next edge
//  3 Gaps: bits 0,(ser_en=0 x2),1,(ser_en=0),1 -> out_word=3'b011; bit_cnt goes 1,1,1,2,2,0
//  4 Backpressure: out_ready=0, send 101 then 010 back-to-back -> out_word stays 101,
//    overflow=1, word_cnt=2; same sequence with out_ready=1 -> both words accepted, overflow=0
//  5 Flush: send 1,1, then flush=1 with ser_en=1 -> bit_cnt=0, no word; then 0,0,1 ->
//    out_word=3'b001
//  6 Reset mid-word: 2 bits in, assert rst_n=0 between edges -> all outputs 0 at once;
//    after release, 3 new bits form a clean word

Source files
------------

// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver: collects NUM_BITS bits MSB first, then presents
// the word and its parity on a valid/ready port with sticky overflow on drop.
module serial_word_rx #(
  parameter int NUM_BITS   = 3,
  parameter int PARITY_ODD = 0,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ser_en,
  input  logic                ser_data,
  input  logic                flush,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [NUM_BITS-1:0] out_word,
  output logic                out_parity,
  output logic [7:0]          bit_cnt,
  output logic [CNT_W-1:0]    word_cnt,
  output logic                overflow
);

  localparam logic [7:0] LAST_BIT = 8'(NUM_BITS - 1);

  function automatic logic parity_f(input logic [NUM_BITS-1:0] word);
    parity_f = (^word) ^ (PARITY_ODD != 0);
  endfunction

  logic [NUM_BITS-1:0] full_word_s;
  logic                complete_s;
  logic                load_s;

  // Only the NUM_BITS-1 earlier bits need storage; the newest bit comes straight from ser_data.
  if (NUM_BITS > 1) begin : g_shift
    logic [NUM_BITS-2:0] shift_word_r;

    assign full_word_s = {shift_word_r, ser_data};

    // Shift register for the bits received so far in the current word
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shift_word_r <= '0;
      end else if (flush) begin
        shift_word_r <= '0;
      end else if (ser_en) begin
        shift_word_r <= full_word_s[NUM_BITS-2:0];
      end else begin
        shift_word_r <= shift_word_r;
      end
    end
  end else begin : g_noshift
    assign full_word_s = ser_data;
  end

  // Completion and output-load decisions for this edge
  always_comb begin
    if (ser_en && !flush && (bit_cnt == LAST_BIT)) begin
      complete_s = 1'b1;
    end else begin
      complete_s = 1'b0;
    end
    load_s = complete_s & (~out_valid | out_ready);
  end

  // Bit counter, word counter, output register and overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= 8'd0;
      word_cnt   <= '0;
      out_valid  <= 1'b0;
      out_word   <= '0;
      out_parity <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (flush) begin
        bit_cnt <= 8'd0;
      end else if (complete_s) begin
        bit_cnt <= 8'd0;
      end else if (ser_en) begin
        bit_cnt <= bit_cnt + 8'd1;
      end else begin
        bit_cnt <= bit_cnt;
      end

      if (complete_s) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end else begin
        word_cnt <= word_cnt;
      end

      // A completing word replaces the held one only if the held one leaves on this edge
      if (load_s) begin
        out_valid  <= 1'b1;
        out_word   <= full_word_s;
        out_parity <= parity_f(full_word_s);
      end else if (out_valid && out_ready) begin
        out_valid  <= 1'b0;
      end else begin
        out_valid  <= out_valid;
      end

      if (complete_s && !load_s) begin
        overflow <= 1'b1;
      end else begin
        overflow <= overflow;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: three configurations driven in parallel and compared every
// cycle against a word-level reference model, plus directed value checks.
module tb_serial_word_rx;

  logic clk = 1'b0;
  logic rst_n, ser_en, ser_data, flush, out_ready;

  logic       ev_valid, ev_par, ev_ovf;
  logic [2:0] ev_word;
  logic [7:0] ev_bcnt, ev_wcnt;
  logic       od_valid, od_par, od_ovf;
  logic [2:0] od_word;
  logic [7:0] od_bcnt, od_wcnt;
  logic       on_valid, on_par, on_ovf;
  logic [0:0] on_word;
  logic [7:0] on_bcnt, on_wcnt;

  int checks = 0;
  int failures = 0;

  int cfg_n   [3] = '{3, 3, 1};
  int cfg_odd [3] = '{0, 1, 0};

  int m_acc [3], m_cnt [3], m_wcnt [3], m_word [3];
  int m_valid [3], m_par [3], m_ovf [3];

  logic [31:0] o_valid [3], o_word [3], o_par [3], o_bcnt [3], o_wcnt [3], o_ovf [3];

  serial_word_rx #(.NUM_BITS(3), .PARITY_ODD(0), .CNT_W(8)) u_even (
    .clk(clk), .rst_n(rst_n), .ser_en(ser_en), .ser_data(ser_data), .flush(flush),
    .out_ready(out_ready), .out_valid(ev_valid), .out_word(ev_word), .out_parity(ev_par),
    .bit_cnt(ev_bcnt), .word_cnt(ev_wcnt), .overflow(ev_ovf));

  serial_word_rx #(.NUM_BITS(3), .PARITY_ODD(1), .CNT_W(8)) u_odd (
    .clk(clk), .rst_n(rst_n), .ser_en(ser_en), .ser_data(ser_data), .flush(flush),
    .out_ready(out_ready), .out_valid(od_valid), .out_word(od_word), .out_parity(od_par),
    .bit_cnt(od_bcnt), .word_cnt(od_wcnt), .overflow(od_ovf));

  serial_word_rx #(.NUM_BITS(1), .PARITY_ODD(0), .CNT_W(8)) u_one (
    .clk(clk), .rst_n(rst_n), .ser_en(ser_en), .ser_data(ser_data), .flush(flush),
    .out_ready(out_ready), .out_valid(on_valid), .out_word(on_word), .out_parity(on_par),
    .bit_cnt(on_bcnt), .word_cnt(on_wcnt), .overflow(on_ovf));

  assign o_valid[0] = 32'(ev_valid); assign o_word[0] = 32'(ev_word); assign o_par[0] = 32'(ev_par);
  assign o_bcnt[0]  = 32'(ev_bcnt);  assign o_wcnt[0] = 32'(ev_wcnt); assign o_ovf[0] = 32'(ev_ovf);
  assign o_valid[1] = 32'(od_valid); assign o_word[1] = 32'(od_word); assign o_par[1] = 32'(od_par);
  assign o_bcnt[1]  = 32'(od_bcnt);  assign o_wcnt[1] = 32'(od_wcnt); assign o_ovf[1] = 32'(od_ovf);
  assign o_valid[2] = 32'(on_valid); assign o_word[2] = 32'(on_word); assign o_par[2] = 32'(on_par);
  assign o_bcnt[2]  = 32'(on_bcnt);  assign o_wcnt[2] = 32'(on_wcnt); assign o_ovf[2] = 32'(on_ovf);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int parity_of(input int word, input int odd);
    int ones = 0;
    for (int b = 0; b < 32; b++) ones += (word >> b) & 1;
    return (ones % 2) ^ odd;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 0; m_cnt[k] = 0; m_wcnt[k] = 0; m_word[k] = 0;
      m_valid[k] = 0; m_par[k] = 0; m_ovf[k] = 0;
    end
  endtask

  // One clock edge of the receiver, described as "append a bit, a word is done after N bits".
  task automatic model_step(input int e, input int d, input int f, input int r);
    for (int k = 0; k < 3; k++) begin
      int done = 0;
      if (f != 0) begin
        m_acc[k] = 0; m_cnt[k] = 0;
      end else if (e != 0) begin
        m_acc[k] = (m_acc[k] * 2 + d) % (1 << cfg_n[k]);
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == cfg_n[k]) begin
          done = 1; m_cnt[k] = 0;
        end
      end
      if (done != 0) begin
        m_wcnt[k] = (m_wcnt[k] + 1) % 256;
        if (m_valid[k] == 0 || r != 0) begin
          m_valid[k] = 1; m_word[k] = m_acc[k]; m_par[k] = parity_of(m_acc[k], cfg_odd[k]);
        end else begin
          m_ovf[k] = 1;
        end
      end else if (m_valid[k] != 0 && r != 0) begin
        m_valid[k] = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("cfg%0d out_valid", k), o_valid[k], 32'(m_valid[k]));
      chk($sformatf("cfg%0d out_word", k),  o_word[k],  32'(m_word[k]));
      chk($sformatf("cfg%0d out_parity", k), o_par[k],  32'(m_par[k]));
      chk($sformatf("cfg%0d bit_cnt", k),   o_bcnt[k],  32'(m_cnt[k]));
      chk($sformatf("cfg%0d word_cnt", k),  o_wcnt[k],  32'(m_wcnt[k]));
      chk($sformatf("cfg%0d overflow", k),  o_ovf[k],   32'(m_ovf[k]));
    end
  endtask

  task automatic cyc(input int e, input int d, input int f, input int r);
    ser_en = e[0]; ser_data = d[0]; flush = f[0]; out_ready = r[0];
    @(posedge clk);
    model_step(e, d, f, r);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    ser_en = 1'b0; ser_data = 1'b0; flush = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ser_en = 1'b0; ser_data = 1'b0; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    #3;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic word 1,0,1 with even parity
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
    chk("t1 valid", 32'(ev_valid), 32'd1);
    chk("t1 word", 32'(ev_word), 32'd5);
    chk("t1 parity", 32'(ev_par), 32'd0);
    chk("t1 word_cnt", 32'(ev_wcnt), 32'd1);

    // Odd parity on 1,1,0 and handshake clearing valid
    do_reset();
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 0, 0, 0);
    chk("t2 word", 32'(od_word), 32'd6);
    chk("t2 parity", 32'(od_par), 32'd1);
    cyc(0, 0, 0, 1);
    chk("t2 valid cleared", 32'(od_valid), 32'd0);

    // Gaps between bits
    do_reset();
    cyc(1, 0, 0, 0); chk("t3 bcnt a", 32'(ev_bcnt), 32'd1);
    cyc(0, 1, 0, 0); chk("t3 bcnt b", 32'(ev_bcnt), 32'd1);
    cyc(0, 0, 0, 0); chk("t3 bcnt c", 32'(ev_bcnt), 32'd1);
    cyc(1, 1, 0, 0); chk("t3 bcnt d", 32'(ev_bcnt), 32'd2);
    cyc(0, 0, 0, 0); chk("t3 bcnt e", 32'(ev_bcnt), 32'd2);
    cyc(1, 1, 0, 0); chk("t3 bcnt f", 32'(ev_bcnt), 32'd0);
    chk("t3 word", 32'(ev_word), 32'd3);

    // Backpressure drops the second word
    do_reset();
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0); cyc(1, 1, 0, 0); cyc(1, 0, 0, 0);
    chk("t4 word held", 32'(ev_word), 32'd5);
    chk("t4 overflow", 32'(ev_ovf), 32'd1);
    chk("t4 word_cnt", 32'(ev_wcnt), 32'd2);

    // Same sequence with the sink always ready
    do_reset();
    cyc(1, 1, 0, 1); cyc(1, 0, 0, 1); cyc(1, 1, 0, 1);
    cyc(1, 0, 0, 1); cyc(1, 1, 0, 1); cyc(1, 0, 0, 1);
    chk("t4b word", 32'(ev_word), 32'd2);
    chk("t4b overflow", 32'(ev_ovf), 32'd0);
    chk("t4b word_cnt", 32'(ev_wcnt), 32'd2);

    // Transfer and reload on the very same edge
    do_reset();
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0); cyc(1, 1, 0, 0); cyc(1, 0, 0, 1);
    chk("t4c valid", 32'(ev_valid), 32'd1);
    chk("t4c word", 32'(ev_word), 32'd2);
    chk("t4c overflow", 32'(ev_ovf), 32'd0);

    // Flush wins over a simultaneous sample
    do_reset();
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 1, 0);
    chk("t5 bcnt", 32'(ev_bcnt), 32'd0);
    chk("t5 no word", 32'(ev_valid), 32'd0);
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
    chk("t5 word", 32'(ev_word), 32'd1);

    // Asynchronous reset in the middle of a word
    do_reset();
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0);
    do_reset();
    chk("t6 bcnt", 32'(ev_bcnt), 32'd0);
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    chk("t6 word", 32'(ev_word), 32'd7);
    chk("t6 parity", 32'(ev_par), 32'd1);

    // Random traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cyc(($urandom_range(0, 9) < 7) ? 1 : 0, int'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0) ? 1 : 0, int'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
